// File: rtl/ex_div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish without iterating.
module ex_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      divOp,
    input  logic [XLEN-1:0] aluOp1,
    input  logic [XLEN-1:0] aluOp2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] divResult
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              in_signed, sign1, sign2;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     rem_sh;
    logic              trial_ok;
    logic [XLEN-1:0]   rem_step, quo_step, quo_fix, rem_fix, final_res;
`ifdef DIV_EARLY_OUT_EN
    logic              div_zero, sgn_ovf;
    logic [XLEN-1:0]   early_res;
`endif

    // Operand capture: magnitudes and result signs for the signed ops.
    always_comb begin
        in_signed = ~divOp[0];
        sign1     = in_signed & aluOp1[XLEN-1];
        sign2     = in_signed & aluOp2[XLEN-1];
        abs1      = sign1 ? -aluOp1 : aluOp1;
        abs2      = sign2 ? -aluOp2 : aluOp2;
    end

    // One restoring step; rem_q < divisor keeps the shifted value within XLEN+1 bits.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial_ok = rem_sh >= {1'b0, dvs_q};
        rem_step = trial_ok ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], trial_ok};
        // A zero divisor leaves the all-ones quotient un-negated.
        quo_fix   = (qneg_q && (dvs_q != '0)) ? -quo_step : quo_step;
        rem_fix   = rneg_q ? -rem_step : rem_step;
        final_res = op_q[1] ? rem_fix : quo_fix;
    end

`ifdef DIV_EARLY_OUT_EN
    always_comb begin
        div_zero = (aluOp2 == '0);
        sgn_ovf  = in_signed && (aluOp1 == {1'b1, {(XLEN-1){1'b0}}}) && (aluOp2 == '1);
        if (div_zero) begin
            early_res = divOp[1] ? aluOp1 : '1;
        end else begin
            early_res = divOp[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        op_d    = op_q;
        res_d   = res_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StCalc;
                        cnt_d   = CNT_W'(XLEN - 1);
                        rem_d   = '0;
                        quo_d   = abs1;
                        dvs_d   = abs2;
                        qneg_d  = sign1 ^ sign2;
                        rneg_d  = sign1;
                        op_d    = divOp;
`ifdef DIV_EARLY_OUT_EN
                        if (div_zero || sgn_ovf) begin
                            state_d = StDone;
                            res_d   = early_res;
                        end
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == '0) begin
                        res_d   = final_res;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q == StCalc);
    assign done      = (state_q == StDone);
    assign divResult = res_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed plan vectors, random ops vs an arithmetic model,
// flush/reset aborts, back-to-back and ignored restarts.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  divOp;
    logic [31:0] aluOp1, aluOp2;
    logic        busy, done;
    logic [31:0] divResult;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    ex_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .divOp     (divOp),
        .aluOp1    (aluOp1),
        .aluOp2    (aluOp2),
        .busy      (busy),
        .done      (done),
        .divResult (divResult)
    );

    always #5 clk = ~clk;

    localparam int ND = 11;
    localparam logic [1:0]  D_OP [ND] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3,
                                          2'd0, 2'd2, 2'd1};
    localparam logic [31:0] D_A  [ND] = '{32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C,
                                          32'h12345678, 32'h12345678, 32'h12345678,
                                          32'h12345678, 32'h80000000, 32'h80000000,
                                          32'h80000000};
    localparam logic [31:0] D_B  [ND] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                                          32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic [31:0] D_R  [ND] = '{32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE,
                                          32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                                          32'h12345678, 32'h80000000, 32'h0, 32'h0};

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return op[1] ? 32'd0 : 32'h80000000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
`endif
        return 33;
    endfunction

    // Drives one start at the current negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bcnt,
                         output int both);
        divOp  = op;
        aluOp1 = a;
        aluOp2 = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        divOp  = 2'($urandom);
        aluOp1 = $urandom;
        aluOp2 = $urandom;
        lat = -1; bcnt = 0; both = 0; res = divResult;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                res = divResult;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; divOp = '0; aluOp1 = '0; aluOp2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || divResult !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b res=%h want 0 0 0", busy, done, divResult);
        end
        last_res = 32'd0;
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat, bcnt, both;
        for (int i = 0; i < ND; i++) begin
            do_op(D_OP[i], D_A[i], D_B[i], res, lat, bcnt, both);
            total++;
            if (res !== D_R[i]) begin
                bad++;
                $display("FAIL directed%0d result: got %h want %h", i, res, D_R[i]);
            end
            total++;
            if (lat !== exp_lat(D_OP[i], D_A[i], D_B[i]) ||
                bcnt !== exp_lat(D_OP[i], D_A[i], D_B[i]) - 1 || both !== 0) begin
                bad++;
                $display("FAIL directed%0d timing: lat=%0d busy=%0d overlap=%0d want %0d %0d 0",
                         i, lat, bcnt, both, exp_lat(D_OP[i], D_A[i], D_B[i]),
                         exp_lat(D_OP[i], D_A[i], D_B[i]) - 1);
            end
            last_res = res;
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || divResult !== last_res) begin
                bad++;
                $display("FAIL directed%0d after-done: done=%b busy=%b res=%h want 0 0 %h",
                         i, done, busy, divResult, last_res);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, want;
        logic [1:0]  op;
        int lat, bcnt, both;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -$urandom_range(1, 15);
                default: ;
            endcase
            want = model(op, a, b);
            do_op(op, a, b, res, lat, bcnt, both);
            total++;
            if (res !== want || lat !== exp_lat(op, a, b) || both !== 0) begin
                bad++;
                $display("FAIL random%0d op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, op, a, b, res, lat, want, exp_lat(op, a, b));
            end
            last_res = res;
            // Half the time start the next op straight from DONE.
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic abort_mid_op(input logic use_rst, output int late_done, output logic b10,
                                output logic b11, output logic d11, output logic [31:0] r11);
        divOp = 2'd1; aluOp1 = 32'd100; aluOp2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        b10 = busy;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        b11 = busy; d11 = done; r11 = divResult;
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
    endtask

    task automatic test_flush();
        int late;
        logic b10, b11, d11;
        logic [31:0] r11;
        abort_mid_op(1'b0, late, b10, b11, d11, r11);
        total++;
        if (b10 !== 1'b1 || b11 !== 1'b0 || d11 !== 1'b0 || r11 !== last_res || late !== 0) begin
            bad++;
            $display("FAIL flush: busy10=%b busy11=%b done11=%b res=%h late=%0d want 1 0 0 %h 0",
                     b10, b11, d11, r11, late, last_res);
        end
        total++;
        if (divResult !== last_res) begin
            bad++;
            $display("FAIL flush hold: got %h want %h", divResult, last_res);
        end
    endtask

    task automatic test_rst_mid();
        int late;
        logic b10, b11, d11;
        logic [31:0] r11;
        abort_mid_op(1'b1, late, b10, b11, d11, r11);
        total++;
        if (b10 !== 1'b1 || b11 !== 1'b0 || d11 !== 1'b0 || r11 !== 32'd0 || late !== 0) begin
            bad++;
            $display("FAIL rst-mid: busy10=%b busy11=%b done11=%b res=%h late=%0d want 1 0 0 0 0",
                     b10, b11, d11, r11, late);
        end
        last_res = 32'd0;
    endtask

    task automatic test_flush_start();
        int viol = 0;
        divOp = 2'd1; aluOp1 = 32'd100; aluOp2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done || divResult !== last_res) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL flush+start: %0d cycles busy/done/changed, want 0", viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bcnt, both;
        do_op(2'd1, 32'd100, 32'd7, res, lat, bcnt, both);
        total++;
        if (res !== 32'd14) begin
            bad++;
            $display("FAIL b2b first: got %h want %h", res, 32'd14);
        end
        do_op(2'd1, 32'd50, 32'd5, res, lat, bcnt, both);
        total++;
        if (res !== 32'd10 || lat !== 33 || bcnt !== 32) begin
            bad++;
            $display("FAIL b2b second: res=%h lat=%0d busy=%0d want %h 33 32",
                     res, lat, bcnt, 32'd10);
        end
        last_res = res;
        @(negedge clk);
    endtask

    task automatic test_restart_ignored();
        int lat = -1;
        logic [31:0] res;
        divOp = 2'd1; aluOp1 = 32'd1000; aluOp2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; divOp = 2'd0; aluOp1 = 32'd7; aluOp2 = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        res = divResult;
        for (int k = 6; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                res = divResult;
                break;
            end
        end
        total++;
        if (res !== 32'd333 || lat !== 33) begin
            bad++;
            $display("FAIL restart-ignored: res=%h lat=%0d want %h 33", res, lat, 32'd333);
        end
        last_res = res;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_rst_mid();
        test_flush_start();
        test_back_to_back();
        test_restart_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide/remainder unit in the EX stage; executes DIV, DIVU, REM, REMU.
- Consumes the forwarded ALU operands produced by the EX operand-forwarding muxes (post-forwarding rs1/rs2 values).
- Holds the pipeline via `busy` while iterating.
- Delivers a 32-bit result to the EX/MEM path with a one-cycle `done` pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; log2(XLEN).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE or DONE.
- flush  input  1  kill the in-flight operation (branch mispredict/trap); synchronous.
- divOp  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- aluOp1  input  32  forwarded dividend (rs1).
- aluOp2  input  32  forwarded divisor (rs2).
- busy  output  1  high while the operation is in progress; hazard unit stalls IF/ID/EX on it.
- done  output  1  one-cycle pulse; `divResult` is valid during this cycle.
- divResult  output  32  quotient or remainder; held until the next accepted start.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, divResult=0, counter=0, internal quotient/remainder/divisor registers=0.
- States and transitions:
  - IDLE: busy=0, done=0.
    - start=1 and flush=0 → CALC.
    - On entry, capture |op1| and |op2|. Absolute value is taken only for DIV/REM; DIVU/REMU use raw values.
    - Also capture the quotient sign (sign1 XOR sign2) and remainder sign (sign1), plus divOp.
    - Counter=31, partial remainder=0.
  - CALC: busy=1.
    - Each cycle: shift the {remainder, dividend} pair left by 1, then trial-subtract the divisor from the remainder.
    - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
    - Exactly 32 CALC cycles.
    - On counter==0: apply sign correction (two's-complement negate where needed), select quotient (DIV/DIVU) or remainder (REM/REMU), register into divResult → DONE.
    - counter decrements by 1 each cycle and never wraps inside CALC.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 → CALC with new operands (back-to-back; no idle bubble).
    - Otherwise → IDLE.
- Latency: start high in cycle 0 → busy=1 in cycles 1..32 → done=1 in cycle 33.
- Divide by zero:
  - Quotient = 0xFFFFFFFF (signed and unsigned).
  - Remainder = dividend.
  - Handled by the natural restoring algorithm plus sign correction being suppressed for a zero divisor.
  - Latency is unchanged when the feature below is disabled.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- Boundary and error conditions:
  - start while in CALC: ignored; operands are not re-sampled.
  - flush in any state: next state IDLE, busy=0, done=0, divResult unchanged.
  - flush and start together: flush wins; nothing is started.
  - rst mid-CALC: all reset values next cycle; no done pulse.
  - Operand stability: operands may change after the start cycle; the unit uses only its captured copies.

Optional Feature:
- Macro: `DIV_EARLY_OUT_EN`.
- Defined:
  - In IDLE/DONE, an accepted start whose divisor==0 or is the signed overflow case skips CALC.
  - Transition goes directly to DONE with the specified special result; done=1 in cycle 1, busy never asserted.
- Undefined:
  - All operations take the full 33-cycle path.
  - Results are identical.

Test Plan:
- DIVU: op1=100, op2=7, start in cycle 0 → busy cycles 1..32; done in cycle 33; divResult=14. REMU with the same operands → divResult=2.
- DIV/REM: op1=0xFFFFFF9C (-100), op2=7 → DIV=0xFFFFFFF2 (-14); REM=0xFFFFFFFE (-2), sign follows the dividend.
- Divide by zero: op1=0x12345678, op2=0 → DIV=DIVU=0xFFFFFFFF; REM=REMU=0x12345678.
  - Without the macro, done arrives in cycle 33.
  - With `DIV_EARLY_OUT_EN`, done arrives in cycle 1 and busy stays 0.
- Overflow: op1=0x80000000, op2=0xFFFFFFFF → DIV=0x80000000, REM=0. Same op as DIVU → divResult=0.
- Flush/reset mid-op: start DIVU 100/7, assert flush in cycle 10 → cycle 11 busy=0, no done pulse ever, divResult keeps its prior value. Repeat with rst in cycle 10 → divResult=0.
- Back-to-back and illegal restart:
  - start asserted during DONE with op1=50, op2=5 → second done 33 cycles later, divResult=10.
  - start pulsed during CALC → ignored; first result unaffected.
